// File: rtl/hack_cpu_hs.sv
// -----------------------------------------------------------------------------
// hack_cpu_hs -- Hack CPU core with valid/stall handshakes on the instruction
// and data-memory read paths. It executes at most one instruction per cycle.
// A-instructions (MSB = 0) load A. C-instructions (MSB = 1) compute an ALU
// result, write it to any of A/D/M, and can branch to the old A.
//
// Parameters
//   WIDTH     data/address/PC width (16..32)
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   instruction  in   instruction word at pc
//   instr_valid  in   instruction word is valid this cycle
//   inM          in   data memory read value at addressM
//   inM_valid    in   inM is valid this cycle
//   outM         out  ALU result (write data for memory)
//   writeM       out  memory write strobe
//   readM        out  current instruction needs M
//   addressM     out  current A register value
//   pc           out  PC register value
//   halted       out  sticky self-jump halt flag
//   retired      out  saturating count of executed instructions
// -----------------------------------------------------------------------------
module hack_cpu_hs #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction,
  input  logic             instr_valid,
  input  logic [WIDTH-1:0] inM,
  input  logic             inM_valid,
  output logic [WIDTH-1:0] outM,
  output logic             writeM,
  output logic             readM,
  output logic [WIDTH-1:0] addressM,
  output logic [WIDTH-1:0] pc,
  output logic             halted,
  output logic [31:0]      retired
);

  // Architectural state
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             halted_q, halted_d;
  logic [31:0]      retired_q, retired_d;

  // Instruction fields
  logic             is_c;
  logic             a_bit;
  logic [5:0]       comp;
  logic [2:0]       dest;   // {A, D, M}
  logic [2:0]       jmp;    // {lt, eq, gt}

  assign is_c  = instruction[WIDTH-1];
  assign a_bit = instruction[12];
  assign comp  = instruction[11:6];
  assign dest  = instruction[5:3];
  assign jmp   = instruction[2:0];

  // Bits WIDTH-2..13 of a C-instruction carry no meaning.
  logic unused_bits;
  assign unused_bits = ^instruction[WIDTH-2:13];

  // ALU: the a bit selects A or M as the y operand.
  logic [WIDTH-1:0] y_op;
  logic [WIDTH-1:0] alu;

  assign y_op = a_bit ? inM : a_q;

  always_comb begin
    // NOTE: assigning a default before the case keeps this block purely
    // combinational; an unassigned path would infer a latch.
    alu = '0;
    unique case ({a_bit, comp})
      7'b0_101010:              alu = '0;
      7'b0_111111:              alu = WIDTH'(1);
      7'b0_111010:              alu = '1;
      7'b0_001100:              alu = d_q;
      7'b0_001101:              alu = ~d_q;
      7'b0_001111:              alu = '0 - d_q;
      7'b0_011111:              alu = d_q + WIDTH'(1);
      7'b0_001110:              alu = d_q - WIDTH'(1);
      7'b0_110000, 7'b1_110000: alu = y_op;
      7'b0_110001, 7'b1_110001: alu = ~y_op;
      7'b0_110011, 7'b1_110011: alu = '0 - y_op;
      7'b0_110111, 7'b1_110111: alu = y_op + WIDTH'(1);
      7'b0_110010, 7'b1_110010: alu = y_op - WIDTH'(1);
      7'b0_000010, 7'b1_000010: alu = d_q + y_op;
      7'b0_010011, 7'b1_010011: alu = d_q - y_op;
      7'b0_000111, 7'b1_000111: alu = y_op - d_q;
      7'b0_000000, 7'b1_000000: alu = d_q & y_op;
      7'b0_010101, 7'b1_010101: alu = d_q | y_op;
      default:                  alu = '0;
    endcase
  end

  // Jump condition on the signed ALU result.
  logic res_lt, res_eq, res_gt, jump_taken;

  assign res_lt     = alu[WIDTH-1];
  assign res_eq     = (alu == '0);
  assign res_gt     = !res_lt && !res_eq;
  assign jump_taken = is_c && |(jmp & {res_lt, res_eq, res_gt});

  // Handshake: a C-instruction that reads M waits for inM_valid.
  logic fire;

  assign readM  = instr_valid && is_c && a_bit && !halted_q;
  assign fire   = instr_valid && !halted_q && !(readM && !inM_valid);
  assign writeM = fire && is_c && dest[0] && !reset;

  assign outM     = alu;
  assign addressM = a_q;
  assign pc       = pc_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

  // Next-state logic; everything holds unless the instruction fires.
  always_comb begin
    a_d       = a_q;
    d_d       = d_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    if (fire) begin
      if (!is_c) begin
        a_d = {1'b0, instruction[WIDTH-2:0]};
      end else begin
        if (dest[2]) a_d = alu;
        if (dest[1]) d_d = alu;
      end
      // The jump target is always the pre-edge A, even if dest includes A.
      pc_d = jump_taken ? a_q : pc_q + WIDTH'(1);
      if (jump_taken && (a_q == pc_q)) halted_d = 1'b1;
      if (retired_q != 32'hFFFF_FFFF) retired_d = retired_q + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      d_q       <= '0;
      pc_q      <= RESET_PC;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      a_q       <= a_d;
      d_q       <= d_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_hack_cpu_hs.sv
// -----------------------------------------------------------------------------
// tb_hack_cpu_hs -- table-driven bench for hack_cpu_hs at WIDTH=16 and
// WIDTH=24. Each vector drives one cycle of inputs, checks the combinational
// outputs before the edge, and pushes the expected post-edge state into a
// scoreboard that is popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_hack_cpu_hs;

  typedef struct {
    bit          w24;      // 1: drive the WIDTH=24 instance
    logic [31:0] instr;
    bit          iv;
    logic [31:0] inm;
    bit          inmv;
    bit          chk_out;
    logic [31:0] out;
    bit          wr;
    bit          rd;
    logic [31:0] addr;     // expected state after the edge
    logic [31:0] pc;
    logic [31:0] ret;
    bit          hlt;
  } vec_t;

  typedef struct {
    string       tag;
    bit          w24;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] ret;
    bit          hlt;
  } post_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        rst16 = 1'b1;
  logic [15:0] instr16 = '0, inm16 = '0;
  logic        iv16 = 1'b0, inmv16 = 1'b0;
  logic [15:0] outm16, addr16, pc16;
  logic        wr16, rd16, hlt16;
  logic [31:0] ret16;

  hack_cpu_hs #(.WIDTH(16), .RESET_PC(16'h0000)) u16 (
    .clk(clk), .reset(rst16), .instruction(instr16), .instr_valid(iv16),
    .inM(inm16), .inM_valid(inmv16), .outM(outm16), .writeM(wr16),
    .readM(rd16), .addressM(addr16), .pc(pc16), .halted(hlt16),
    .retired(ret16)
  );

  // WIDTH=24 instance
  logic        rst24 = 1'b1;
  logic [23:0] instr24 = '0, inm24 = '0;
  logic        iv24 = 1'b0, inmv24 = 1'b0;
  logic [23:0] outm24, addr24, pc24;
  logic        wr24, rd24, hlt24;
  logic [31:0] ret24;

  hack_cpu_hs #(.WIDTH(24), .RESET_PC(24'h000010)) u24 (
    .clk(clk), .reset(rst24), .instruction(instr24), .instr_valid(iv24),
    .inM(inm24), .inM_valid(inmv24), .outM(outm24), .writeM(wr24),
    .readM(rd24), .addressM(addr24), .pc(pc24), .halted(hlt24),
    .retired(ret24)
  );

  vec_t  tbl[$];
  post_t sb[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w24, logic [31:0] instr, bit iv,
                              logic [31:0] inm, bit inmv, bit chk_out,
                              logic [31:0] out, bit wr, bit rd,
                              logic [31:0] addr, logic [31:0] pc,
                              logic [31:0] ret, bit hlt);
    vec_t v;
    v.w24 = w24; v.instr = instr; v.iv = iv; v.inm = inm; v.inmv = inmv;
    v.chk_out = chk_out; v.out = out; v.wr = wr; v.rd = rd;
    v.addr = addr; v.pc = pc; v.ret = ret; v.hlt = hlt;
    return v;
  endfunction

  // 16-bit C-instruction code re-encoded for the 24-bit instance.
  function automatic logic [31:0] c24(logic [15:0] c16);
    return 32'h0080_0000 | {19'd0, c16[12:0]};
  endfunction

  task automatic check_state(input string tag, input bit w24,
                             input logic [31:0] addr, input logic [31:0] pc,
                             input logic [31:0] ret, input bit hlt);
    check({tag, ".addressM"}, w24 ? 32'(addr24) : 32'(addr16), addr);
    check({tag, ".pc"},       w24 ? 32'(pc24)   : 32'(pc16),   pc);
    check({tag, ".retired"},  w24 ? ret24       : ret16,       ret);
    check({tag, ".halted"},   w24 ? 32'(hlt24)  : 32'(hlt16),  32'(hlt));
  endtask

  // One cycle: drive, check combinational outputs, edge, check state.
  task automatic step(input string tag, input vec_t v);
    post_t p;
    iv16 = 1'b0; iv24 = 1'b0;
    if (v.w24) begin
      instr24 = v.instr[23:0]; iv24 = v.iv;
      inm24 = v.inm[23:0]; inmv24 = v.inmv;
    end else begin
      instr16 = v.instr[15:0]; iv16 = v.iv;
      inm16 = v.inm[15:0]; inmv16 = v.inmv;
    end
    #1;
    if (v.chk_out)
      check({tag, ".outM"}, v.w24 ? 32'(outm24) : 32'(outm16), v.out);
    check({tag, ".writeM"}, v.w24 ? 32'(wr24) : 32'(wr16), 32'(v.wr));
    check({tag, ".readM"},  v.w24 ? 32'(rd24) : 32'(rd16), 32'(v.rd));
    p.tag = tag; p.w24 = v.w24; p.addr = v.addr; p.pc = v.pc;
    p.ret = v.ret; p.hlt = v.hlt;
    sb.push_back(p);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      p = sb.pop_front();
      check_state(p.tag, p.w24, p.addr, p.pc, p.ret, p.hlt);
    end
  endtask

  initial begin
    // WIDTH=16 main sequence
    tbl.push_back(mk(0, 32'h0AA1, 1, 0, 0, 0, 0, 0, 0, 32'h0AA1, 1, 1, 0));
    tbl.push_back(mk(0, 32'hEC08, 1, 0, 0, 1, 32'h0AA1, 1, 0, 32'h0AA1, 2, 2, 0));
    for (int k = 0; k < 3; k++)  // AM=M+1 stalled on inM_valid
      tbl.push_back(mk(0, 32'hFDE8, 1, 32'h0AA1, 0, 1, 32'h0AA2, 0, 1, 32'h0AA1, 2, 2, 0));
    tbl.push_back(mk(0, 32'hFDE8, 1, 32'h0AA1, 1, 1, 32'h0AA2, 1, 1, 32'h0AA2, 3, 3, 0));
    for (int k = 0; k < 2; k++)  // bubbles
      tbl.push_back(mk(0, 32'hEC08, 0, 0, 0, 1, 32'h0AA2, 0, 0, 32'h0AA2, 3, 3, 0));
    tbl.push_back(mk(0, 32'hEC10, 1, 0, 0, 1, 32'h0AA2, 0, 0, 32'h0AA2, 4, 4, 0));   // D=A
    tbl.push_back(mk(0, 32'hE388, 1, 0, 0, 1, 32'h0AA1, 1, 0, 32'h0AA2, 5, 5, 0));   // M=D-1
    tbl.push_back(mk(0, 32'h00FF, 1, 0, 0, 0, 0, 0, 0, 32'h00FF, 6, 6, 0));
    tbl.push_back(mk(0, 32'hE008, 1, 0, 0, 1, 32'h00A2, 1, 0, 32'h00FF, 7, 7, 0));   // M=D&A
    tbl.push_back(mk(0, 32'hE548, 1, 0, 0, 1, 32'h0AFF, 1, 0, 32'h00FF, 8, 8, 0));   // M=D|A
    tbl.push_back(mk(0, 32'hE1C8, 1, 0, 0, 1, 32'hF65D, 1, 0, 32'h00FF, 9, 9, 0));   // M=A-D
    tbl.push_back(mk(0, 32'hEE88, 1, 0, 0, 1, 32'hFFFF, 1, 0, 32'h00FF, 10, 10, 0)); // M=-1
    tbl.push_back(mk(0, 32'hE348, 1, 0, 0, 1, 32'hF55D, 1, 0, 32'h00FF, 11, 11, 0)); // M=!D
    tbl.push_back(mk(0, 32'hFA88, 1, 32'h1234, 1, 1, 0, 1, 1, 32'h00FF, 12, 12, 0)); // undefined
    tbl.push_back(mk(0, 32'h0014, 1, 0, 0, 0, 0, 0, 0, 32'h0014, 13, 13, 0));
    tbl.push_back(mk(0, 32'hEDE7, 1, 0, 0, 1, 32'h0015, 0, 0, 32'h0015, 32'h14, 14, 0)); // A=A+1;JMP
    tbl.push_back(mk(0, 32'h0005, 1, 0, 0, 0, 0, 0, 0, 5, 32'h15, 15, 0));
    tbl.push_back(mk(0, 32'hEA87, 1, 0, 0, 1, 0, 0, 0, 5, 5, 16, 0));                // 0;JMP to 5
    tbl.push_back(mk(0, 32'hEA87, 1, 0, 0, 1, 0, 0, 0, 5, 5, 17, 1));                // self-jump
    tbl.push_back(mk(0, 32'hEC08, 1, 0, 0, 1, 5, 0, 0, 5, 5, 17, 1));                // halted
    tbl.push_back(mk(0, 32'hFDE8, 1, 32'h0AA1, 0, 1, 32'h0AA2, 0, 0, 5, 5, 17, 1));
    // WIDTH=24 signed jump sequence (RESET_PC = 0x10)
    tbl.push_back(mk(1, 32'h3FFFFF, 1, 0, 0, 0, 0, 0, 0, 32'h3FFFFF, 32'h11, 1, 0));
    tbl.push_back(mk(1, c24(16'hEC10), 1, 0, 0, 1, 32'h3FFFFF, 0, 0, 32'h3FFFFF, 32'h12, 2, 0));
    tbl.push_back(mk(1, c24(16'hE7D0), 1, 0, 0, 1, 32'h400000, 0, 0, 32'h3FFFFF, 32'h13, 3, 0));
    tbl.push_back(mk(1, c24(16'hE301), 1, 0, 0, 1, 32'h400000, 0, 0, 32'h3FFFFF, 32'h3FFFFF, 4, 0));
    tbl.push_back(mk(1, c24(16'hE304), 1, 0, 0, 1, 32'h400000, 0, 0, 32'h3FFFFF, 32'h400000, 5, 0));

    // Reset both instances
    repeat (2) @(posedge clk);
    #1;
    rst16 = 1'b0; rst24 = 1'b0;
    check_state("reset16", 0, 0, 0, 0, 0);
    check_state("reset24", 1, 0, 32'h10, 0, 0);

    foreach (tbl[i]) step($sformatf("v%0d", i), tbl[i]);

    // Reset while halted with a firing M-write presented: reset wins.
    rst16 = 1'b1; instr16 = 16'hEC08; iv16 = 1'b1; inmv16 = 1'b0;
    #1;
    check("rst_prio.writeM", 32'(wr16), 0);
    @(posedge clk); #1;
    check_state("rst_prio", 0, 0, 0, 0, 0);
    @(posedge clk); #1;   // second reset cycle with valid M=A still no effect
    check("rst_hold.writeM", 32'(wr16), 0);
    check_state("rst_hold", 0, 0, 0, 0, 0);
    rst16 = 1'b0;
    step("post_rst", mk(0, 32'h0AA1, 1, 0, 0, 0, 0, 0, 0, 32'h0AA1, 1, 1, 0));

    if (sb.size() != 0) check("scoreboard_leftover", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
